// File: rtl/wb_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_stream_pkg
// Description : Shared message layout and state encoding for the Wishbone
//               stream master and its slave-side counterpart.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_stream_pkg;

    // Command message: [68] we, [67:64] sel, [63:32] dat, [31:0] adr
    localparam int CMD_W   = 69;
    localparam int WE_BIT  = 68;
    localparam int SEL_LSB = 64;
    localparam int DAT_LSB = 32;
    localparam int ADR_LSB = 0;

    // Response message: [32] err, [31:0] data
    localparam int RESP_W  = 33;
    localparam int ERR_BIT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : wb_timeout_counter
// Description : Saturating cycle counter with synchronous clear and an
//               expired flag raised while the count equals LIMIT-1.
//               LIMIT = 0 disables expiry entirely.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // A zero limit still needs a legal one-bit register.
    localparam int unsigned CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count;

    // Count enabled cycles, holding at the maximum value instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    if (LIMIT > 0) begin : g_limit
        localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
        assign expired = (count == LAST);
    end else begin : g_no_limit
        assign expired = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/wb_stream_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_stream_master
// Description : Wishbone classic-cycle initiator fed by a val/rdy command
//               stream. One single-beat read or write per command, one
//               outstanding transaction, response returned with an error
//               flag on a val/rdy response stream. A timeout aborts cycles
//               to a slave that never answers.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stream_master
    import wb_stream_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              cmd_val,
    output logic              cmd_rdy,
    input  logic [CMD_W-1:0]  cmd_msg,
    output logic              resp_val,
    input  logic              resp_rdy,
    output logic [RESP_W-1:0] resp_msg,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [31:0]       wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    input  logic [31:0]       wbm_dat_i,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i
);

    state_t            state;
    state_t            state_next;
    logic              started;      // set on the first edge after reset release
    logic              accept;
    logic              capture;
    logic              in_bus;
    logic              expired;
    logic              cmd_we;
    logic [3:0]        cmd_sel;
    logic [31:0]       cmd_adr;
    logic [31:0]       cmd_dat;
    logic [RESP_W-1:0] resp_q;
    logic [RESP_W-1:0] resp_next;

    assign in_bus = (state == BUS);

    // State register plus the post-reset ready enable.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state   <= IDLE;
            started <= 1'b0;
        end else begin
            state   <= state_next;
            started <= 1'b1;
        end
    end

    // Next state, handshakes and response capture; ack beats err beats timeout.
    always_comb begin
        state_next = state;
        cmd_rdy    = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        resp_next  = '0;
        case (state)
            IDLE: begin
                cmd_rdy = started;
                if (cmd_val && started) begin
                    accept     = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    capture                = 1'b1;
                    resp_next[ERR_BIT-1:0] = cmd_we ? 32'h0 : wbm_dat_i;
                    state_next             = RESP;
                end else if (wbm_err_i || expired) begin
                    capture            = 1'b1;
                    resp_next[ERR_BIT] = 1'b1;
                    state_next         = RESP;
                end
            end
            RESP: begin
                if (resp_rdy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command fields are latched once at accept and held for the whole cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cmd_we  <= 1'b0;
            cmd_sel <= '0;
            cmd_adr <= '0;
            cmd_dat <= '0;
        end else if (accept) begin
            cmd_we  <= cmd_msg[WE_BIT];
            cmd_sel <= cmd_msg[SEL_LSB +: 4];
            cmd_adr <= cmd_msg[ADR_LSB +: 32];
            cmd_dat <= cmd_msg[DAT_LSB +: 32];
        end
    end

    // Response is captured at the terminating edge and held through any stall.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            resp_q <= '0;
        end else if (capture) begin
            resp_q <= resp_next;
        end
    end

    wb_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .clear   (accept),
        .enable  (in_bus && !wbm_ack_i && !wbm_err_i),
        .expired (expired)
    );

    // Bus outputs decode straight from state so reset drops them at once.
    assign wbm_cyc_o = in_bus;
    assign wbm_stb_o = in_bus;
    assign wbm_we_o  = in_bus & cmd_we;
    assign wbm_sel_o = in_bus ? cmd_sel : 4'h0;
    assign wbm_adr_o = in_bus ? cmd_adr : 32'h0;
    assign wbm_dat_o = in_bus ? cmd_dat : 32'h0;

    assign resp_val  = (state == RESP);
    assign resp_msg  = resp_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stream_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stream_master
// Description : Self-checking bench for wb_stream_master: one DUT with an
//               8-cycle timeout and one with the timeout disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stream_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main DUT, TIMEOUT_CYCLES = 8
    logic        cmd_val, cmd_rdy, resp_val, resp_rdy;
    logic [68:0] cmd_msg;
    logic [32:0] resp_msg;
    logic        cyc, stb, we, ack, err;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;

    // Second DUT, timeout disabled
    logic        cmd_val0, cmd_rdy0, resp_val0, resp_rdy0;
    logic [68:0] cmd_msg0;
    logic [32:0] resp_msg0;
    logic        cyc0, stb0, we0, ack0, err0;
    logic [3:0]  sel0;
    logic [31:0] adr0, dat_o0, dat_i0;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    wb_stream_master #(.TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i (clk),      .wb_rst_ni (rst_n),
        .cmd_val  (cmd_val),  .cmd_rdy   (cmd_rdy),  .cmd_msg  (cmd_msg),
        .resp_val (resp_val), .resp_rdy  (resp_rdy), .resp_msg (resp_msg),
        .wbm_cyc_o(cyc),      .wbm_stb_o (stb),      .wbm_we_o (we),
        .wbm_sel_o(sel),      .wbm_adr_o (adr),      .wbm_dat_o(dat_o),
        .wbm_dat_i(dat_i),    .wbm_ack_i (ack),      .wbm_err_i(err)
    );

    wb_stream_master #(.TIMEOUT_CYCLES(0)) dut0 (
        .wb_clk_i (clk),       .wb_rst_ni (rst_n),
        .cmd_val  (cmd_val0),  .cmd_rdy   (cmd_rdy0),  .cmd_msg  (cmd_msg0),
        .resp_val (resp_val0), .resp_rdy  (resp_rdy0), .resp_msg (resp_msg0),
        .wbm_cyc_o(cyc0),      .wbm_stb_o (stb0),      .wbm_we_o (we0),
        .wbm_sel_o(sel0),      .wbm_adr_o (adr0),      .wbm_dat_o(dat_o0),
        .wbm_dat_i(dat_i0),    .wbm_ack_i (ack0),      .wbm_err_i(err0)
    );

    // Reference model: mode 0 ack, 1 err, 2 ack+err, 3 silent; slave answers
    // in BUS cycle waits+1; the 8-cycle timeout fires if that is too late.
    function automatic int exp_stb(input int waits, input int mode);
        if (mode == 3 || waits + 1 > 8) return 8;
        return waits + 1;
    endfunction

    function automatic logic [32:0] exp_resp(input logic t_we, input logic [31:0] rdata,
                                             input int waits, input int mode);
        if (mode == 3 || waits + 1 > 8) return {1'b1, 32'h0};
        if (mode == 1) return {1'b1, 32'h0};
        return {1'b0, (t_we ? 32'h0 : rdata)};
    endfunction

    // Stimulus driver acting as command source and Wishbone slave; called at a
    // negedge, returns at a negedge after the response handshake.
    task automatic do_txn(input logic t_we, input logic [3:0] t_sel,
                          input logic [31:0] t_adr, input logic [31:0] t_dat,
                          input logic [31:0] t_rdata, input int waits,
                          input int mode, input int stall,
                          output int stb_cycles, output int resp_at,
                          output logic [32:0] resp, output bit fields_ok,
                          output bit stall_ok);
        int n;
        cmd_val = 1'b1;
        cmd_msg = {t_we, t_sel, t_dat, t_adr};
        n = 0;
        while (cmd_rdy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cmd_val    = 1'b0;
        cmd_msg    = '0;
        stb_cycles = 0;
        resp_at    = -1;
        resp       = '0;
        fields_ok  = 1'b1;
        stall_ok   = 1'b1;
        for (int c = 0; c < 200; c++) begin
            ack   = 1'b0;
            err   = 1'b0;
            dat_i = ~t_rdata;
            if (resp_val === 1'b1) begin
                resp_at = c;
                break;
            end
            if (stb === 1'b1) begin
                stb_cycles++;
                if (cyc !== 1'b1 || we !== t_we || sel !== t_sel || adr !== t_adr ||
                    dat_o !== t_dat || cmd_rdy !== 1'b0)
                    fields_ok = 1'b0;
                if (stb_cycles == waits + 1) begin
                    if (mode == 0 || mode == 2) begin
                        ack   = 1'b1;
                        dat_i = t_rdata;
                    end
                    if (mode == 1 || mode == 2) err = 1'b1;
                end
            end
            @(negedge clk);
        end
        if (resp_at >= 0) begin
            resp = resp_msg;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                if (resp_val !== 1'b1 || resp_msg !== resp || cmd_rdy !== 1'b0 || stb !== 1'b0)
                    stall_ok = 1'b0;
            end
            resp_rdy = 1'b1;
            @(negedge clk);
            resp_rdy = 1'b0;
            if (resp_val !== 1'b0 || cmd_rdy !== 1'b1) stall_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_val = 0; cmd_msg = '0; resp_rdy = 0; ack = 0; err = 0; dat_i = '0;
        cmd_val0 = 0; cmd_msg0 = '0; resp_rdy0 = 0; ack0 = 0; err0 = 0; dat_i0 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_rdy !== 1'b0) begin
            errors++; $display("FAIL rst_cmd_rdy: got %b expected 0", cmd_rdy);
        end
        checks++;
        if (resp_val !== 1'b0 || resp_msg !== 33'h0) begin
            errors++; $display("FAIL rst_resp: got val=%b msg=%h expected 0/0", resp_val, resp_msg);
        end
        checks++;
        if ({cyc, stb, we, sel, adr, dat_o} !== '0) begin
            errors++; $display("FAIL rst_wbm: got cyc=%b stb=%b adr=%h expected all 0", cyc, stb, adr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_rdy !== 1'b1 || cmd_rdy0 !== 1'b1) begin
            errors++; $display("FAIL rst_release_rdy: got %b/%b expected 1/1", cmd_rdy, cmd_rdy0);
        end
    endtask

    task automatic test_zero_wait_write();
        int sc, ra; logic [32:0] r, e; bit fo, so;
        exp_q.push_back(33'h0_0000_0000);
        do_txn(1'b1, 4'hF, 32'h3000_0000, 32'hA5A5_0001, 32'hDEAD_BEEF, 0, 0, 0, sc, ra, r, fo, so);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin errors++; $display("FAIL zw_resp: got %h expected %h", r, e); end
        checks++;
        if (sc !== 1 || ra !== 1) begin
            errors++; $display("FAIL zw_timing: got stb=%0d resp_at=%0d expected 1/1", sc, ra);
        end
        checks++;
        if (!fo || !so) begin errors++; $display("FAIL zw_fields: got fields=%b hs=%b expected 1/1", fo, so); end
    endtask

    task automatic test_read_wait();
        int sc, ra; logic [32:0] r, e; bit fo, so;
        exp_q.push_back({1'b0, 32'h1234_5678});
        do_txn(1'b0, 4'h3, 32'h3000_0010, 32'h0BAD_0BAD, 32'h1234_5678, 3, 0, 0, sc, ra, r, fo, so);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin errors++; $display("FAIL rd_resp: got %h expected %h", r, e); end
        checks++;
        if (sc !== 4 || ra !== 4 || !fo) begin
            errors++; $display("FAIL rd_timing: got stb=%0d resp_at=%0d fields=%b expected 4/4/1", sc, ra, fo);
        end
    endtask

    task automatic test_slave_err();
        int sc, ra; logic [32:0] r, e; bit fo, so;
        exp_q.push_back({1'b1, 32'h0});
        do_txn(1'b0, 4'h1, 32'h3000_0020, 32'h0, 32'h5555_AAAA, 1, 1, 0, sc, ra, r, fo, so);
        e = exp_q.pop_front();
        checks++;
        if (r !== e || sc !== 2) begin
            errors++; $display("FAIL err_resp: got %h stb=%0d expected %h stb=2", r, sc, e);
        end
        exp_q.push_back({1'b0, 32'hCAFE_F00D});
        do_txn(1'b0, 4'hC, 32'h3000_0024, 32'h0, 32'hCAFE_F00D, 0, 2, 0, sc, ra, r, fo, so);
        e = exp_q.pop_front();
        checks++;
        if (r !== e || sc !== 1) begin
            errors++; $display("FAIL ackerr_resp: got %h stb=%0d expected %h stb=1", r, sc, e);
        end
    endtask

    task automatic test_timeout();
        int sc, ra; logic [32:0] r, e; bit fo, so;
        exp_q.push_back({1'b1, 32'h0});
        do_txn(1'b0, 4'hF, 32'h3000_0030, 32'h0, 32'h7777_7777, 0, 3, 0, sc, ra, r, fo, so);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin errors++; $display("FAIL to_resp: got %h expected %h", r, e); end
        checks++;
        if (sc !== 8 || !fo) begin errors++; $display("FAIL to_stb_len: got %0d expected 8", sc); end
        // Ack in the very cycle the timeout would fire must win.
        exp_q.push_back({1'b0, 32'h8888_0001});
        do_txn(1'b0, 4'hF, 32'h3000_0034, 32'h0, 32'h8888_0001, 7, 0, 0, sc, ra, r, fo, so);
        e = exp_q.pop_front();
        checks++;
        if (r !== e || sc !== 8) begin
            errors++; $display("FAIL to_ack_last: got %h stb=%0d expected %h stb=8", r, sc, e);
        end
    endtask

    task automatic test_backpressure();
        int sc, ra; logic [32:0] r, e; bit fo, so;
        exp_q.push_back({1'b0, 32'h0F0F_1234});
        do_txn(1'b0, 4'h6, 32'h3000_0040, 32'h0, 32'h0F0F_1234, 1, 0, 5, sc, ra, r, fo, so);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin errors++; $display("FAIL bp_resp: got %h expected %h", r, e); end
        checks++;
        if (!so) begin errors++; $display("FAIL bp_stall: got stable=%b expected 1", so); end
    endtask

    task automatic test_back_to_back();
        int sc, ra; logic [32:0] r, e; bit fo, so;
        logic t_we; logic [3:0] t_sel; logic [31:0] t_adr, t_dat, t_rd;
        int waits, mode, stall;
        for (int i = 0; i < 16; i++) begin
            t_we  = 1'($urandom_range(0, 1));
            t_sel = 4'($urandom);
            t_adr = 32'h3000_0000 | 32'($urandom_range(0, 255) * 4);
            t_dat = $urandom;
            t_rd  = $urandom;
            waits = $urandom_range(0, 9);
            mode  = $urandom_range(0, 3);
            stall = $urandom_range(0, 3);
            exp_q.push_back(exp_resp(t_we, t_rd, waits, mode));
            do_txn(t_we, t_sel, t_adr, t_dat, t_rd, waits, mode, stall, sc, ra, r, fo, so);
            e = exp_q.pop_front();
            checks++;
            if (r !== e) begin
                errors++; $display("FAIL b2b_resp[%0d]: got %h expected %h", i, r, e);
            end
            checks++;
            if (sc !== exp_stb(waits, mode) || ra !== sc) begin
                errors++; $display("FAIL b2b_stb[%0d]: got %0d/%0d expected %0d", i, sc, ra, exp_stb(waits, mode));
            end
            checks++;
            if (!fo || !so) begin
                errors++; $display("FAIL b2b_hs[%0d]: got fields=%b hs=%b expected 1/1", i, fo, so);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_queue: got %0d left expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_bus();
        int sc, ra, n; logic [32:0] r, e; bit fo, so;
        cmd_val = 1'b1;
        cmd_msg = {1'b0, 4'hF, 32'h0, 32'h3000_0050};
        n = 0;
        while (cmd_rdy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_val = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (stb !== 1'b1) begin errors++; $display("FAIL rm_pre_stb: got %b expected 1", stb); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (cyc !== 1'b0 || stb !== 1'b0 || resp_val !== 1'b0) begin
            errors++; $display("FAIL rm_async_drop: got cyc=%b stb=%b val=%b expected 0", cyc, stb, resp_val);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_val !== 1'b0 || stb !== 1'b0 || cmd_rdy !== 1'b1) begin
            errors++; $display("FAIL rm_after: got val=%b stb=%b rdy=%b expected 0/0/1", resp_val, stb, cmd_rdy);
        end
        exp_q.push_back({1'b0, 32'h0});
        do_txn(1'b1, 4'h5, 32'h3000_0054, 32'h1357_9BDF, 32'hFFFF_0000, 2, 0, 1, sc, ra, r, fo, so);
        e = exp_q.pop_front();
        checks++;
        if (r !== e || sc !== 3 || !fo || !so) begin
            errors++; $display("FAIL rm_next_txn: got %h stb=%0d expected %h stb=3", r, sc, e);
        end
    endtask

    task automatic test_no_timeout();
        int n, bad;
        cmd_val0 = 1'b1;
        cmd_msg0 = {1'b0, 4'hF, 32'h0, 32'h3000_0060};
        n = 0;
        while (cmd_rdy0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_val0 = 1'b0;
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            if (stb0 !== 1'b1 || cyc0 !== 1'b1 || resp_val0 !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL nt_hold: got %0d bad cycles expected 0", bad); end
        err0 = 1'b1;
        @(negedge clk);
        err0 = 1'b0;
        checks++;
        if (resp_val0 !== 1'b1 || resp_msg0 !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL nt_err_resp: got val=%b msg=%h expected 1/%h", resp_val0, resp_msg0, {1'b1, 32'h0});
        end
        resp_rdy0 = 1'b1;
        @(negedge clk);
        resp_rdy0 = 1'b0;
        checks++;
        if (resp_val0 !== 1'b0 || cmd_rdy0 !== 1'b1) begin
            errors++; $display("FAIL nt_handshake: got val=%b rdy=%b expected 0/1", resp_val0, cmd_rdy0);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_read_wait();
        test_slave_err();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_bus();
        test_no_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
